// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: control decode, register file, immediates, ID/EX register
//
// Ports:
//   clk_i, reset_i                      clock, synchronous active-high reset
//   pc_DECODE, instruction_DECODE       instruction in decode, from IF/ID
//   RegWrite/rd/Result_WRITEBACK        register file write port
//   stall_DECODE, flush_EXECUTE         hold / bubble the ID/EX register
//   rs1_DECODE, rs2_DECODE              combinational source indices for the hazard unit
//   *_EXECUTE                           ID/EX register contents feeding execute
//
// Optional feature: define REGFILE_BYPASS_EN to make the register file
// write-through (a same-cycle write to the read address is returned).
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] pc_DECODE,
  input  logic [31:0]     instruction_DECODE,
  input  logic            RegWrite_WRITEBACK,
  input  logic [4:0]      rd_WRITEBACK,
  input  logic [XLEN-1:0] Result_WRITEBACK,
  input  logic            stall_DECODE,
  input  logic            flush_EXECUTE,
  output logic [4:0]      rs1_DECODE,
  output logic [4:0]      rs2_DECODE,
  output logic            RegWrite_EXECUTE,
  output logic            MemWrite_EXECUTE,
  output logic            Jump_EXECUTE,
  output logic            Branch_EXECUTE,
  output logic            ALUSrc_EXECUTE,
  output logic [1:0]      ResultSrc_EXECUTE,
  output logic [2:0]      ALUControl_EXECUTE,
  output logic [XLEN-1:0] RD1_EXECUTE,
  output logic [XLEN-1:0] RD2_EXECUTE,
  output logic [XLEN-1:0] ImmExt_EXECUTE,
  output logic [XLEN-1:0] pc_EXECUTE,
  output logic [XLEN-1:0] PCPlus4_EXECUTE,
  output logic [4:0]      rs1_EXECUTE,
  output logic [4:0]      rs2_EXECUTE,
  output logic [4:0]      rd_EXECUTE
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rd_d;

  assign opcode     = instruction_DECODE[6:0];
  assign funct3     = instruction_DECODE[14:12];
  assign funct7_b5  = instruction_DECODE[30];
  assign rd_d       = instruction_DECODE[11:7];
  assign rs1_DECODE = instruction_DECODE[19:15];
  assign rs2_DECODE = instruction_DECODE[24:20];

  // Immediate formats, all sign-extended from instr[31]
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{(XLEN-12){instruction_DECODE[31]}}, instruction_DECODE[31:20]};
  assign imm_s = {{(XLEN-12){instruction_DECODE[31]}}, instruction_DECODE[31:25],
                  instruction_DECODE[11:7]};
  assign imm_b = {{(XLEN-12){instruction_DECODE[31]}}, instruction_DECODE[7],
                  instruction_DECODE[30:25], instruction_DECODE[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){instruction_DECODE[31]}}, instruction_DECODE[19:12],
                  instruction_DECODE[20], instruction_DECODE[30:21], 1'b0};

  // ALU operation from funct3; the funct7 sub bit only matters for R-type,
  // since for addi instr[30] is part of the immediate.
  logic [2:0] alu_funct;
  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3)
      3'b000:  alu_funct = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct = ALU_SLT;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: alu_funct = ALU_ADD;
    endcase
  end

  logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]      result_src_d;
  logic [2:0]      alu_ctrl_d;
  logic [XLEN-1:0] imm_d;

  // Unrecognised opcodes decode to all-zero controls so they behave as bubbles.
  // Loads, stores and jal use the ALU as an adder regardless of funct3.
  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    result_src_d = 2'b00;
    alu_ctrl_d   = ALU_ADD;
    imm_d        = '0;
    case (opcode)
      OP_LW: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b01;
        imm_d        = imm_i;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = imm_s;
      end
      OP_R: begin
        reg_write_d = 1'b1;
        alu_ctrl_d  = alu_funct;
      end
      OP_BEQ: begin
        branch_d   = 1'b1;
        alu_ctrl_d = ALU_SUB;
        imm_d      = imm_b;
      end
      OP_IALU: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_ctrl_d  = alu_funct;
        imm_d       = imm_i;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        result_src_d = 2'b10;
        imm_d        = imm_j;
      end
      default: ;
    endcase
  end

  // Register file: x0 is never written and always reads as zero
  logic [XLEN-1:0] regs [NREGS];
  logic            wb_en;
  assign wb_en = RegWrite_WRITEBACK && (rd_WRITEBACK != 5'd0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[rd_WRITEBACK] <= Result_WRITEBACK;
    end
  end

  logic [XLEN-1:0] rd1_d, rd2_d;
  always_comb begin
    rd1_d = (rs1_DECODE == 5'd0) ? '0 : regs[rs1_DECODE];
    rd2_d = (rs2_DECODE == 5'd0) ? '0 : regs[rs2_DECODE];
`ifdef REGFILE_BYPASS_EN
    if (wb_en && rd_WRITEBACK == rs1_DECODE) rd1_d = Result_WRITEBACK;
    if (wb_en && rd_WRITEBACK == rs2_DECODE) rd2_d = Result_WRITEBACK;
`else
`endif
  end

  // ID/EX pipeline register: reset > flush > stall > load
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_EXECUTE) begin
      RegWrite_EXECUTE   <= 1'b0;
      MemWrite_EXECUTE   <= 1'b0;
      Jump_EXECUTE       <= 1'b0;
      Branch_EXECUTE     <= 1'b0;
      ALUSrc_EXECUTE     <= 1'b0;
      ResultSrc_EXECUTE  <= 2'b00;
      ALUControl_EXECUTE <= 3'b000;
      RD1_EXECUTE        <= '0;
      RD2_EXECUTE        <= '0;
      ImmExt_EXECUTE     <= '0;
      pc_EXECUTE         <= '0;
      PCPlus4_EXECUTE    <= '0;
      rs1_EXECUTE        <= 5'd0;
      rs2_EXECUTE        <= 5'd0;
      rd_EXECUTE         <= 5'd0;
    end else if (!stall_DECODE) begin
      RegWrite_EXECUTE   <= reg_write_d;
      MemWrite_EXECUTE   <= mem_write_d;
      Jump_EXECUTE       <= jump_d;
      Branch_EXECUTE     <= branch_d;
      ALUSrc_EXECUTE     <= alu_src_d;
      ResultSrc_EXECUTE  <= result_src_d;
      ALUControl_EXECUTE <= alu_ctrl_d;
      RD1_EXECUTE        <= rd1_d;
      RD2_EXECUTE        <= rd2_d;
      ImmExt_EXECUTE     <= imm_d;
      pc_EXECUTE         <= pc_DECODE;
      PCPlus4_EXECUTE    <= pc_DECODE + XLEN'(4);
      rs1_EXECUTE        <= rs1_DECODE;
      rs2_EXECUTE        <= rs2_DECODE;
      rd_EXECUTE         <= rd_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage with a reference model
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pc_DECODE, instruction_DECODE;
  logic        RegWrite_WRITEBACK;
  logic [4:0]  rd_WRITEBACK;
  logic [31:0] Result_WRITEBACK;
  logic        stall_DECODE, flush_EXECUTE;
  logic [4:0]  rs1_DECODE, rs2_DECODE;
  logic        RegWrite_EXECUTE, MemWrite_EXECUTE, Jump_EXECUTE, Branch_EXECUTE, ALUSrc_EXECUTE;
  logic [1:0]  ResultSrc_EXECUTE;
  logic [2:0]  ALUControl_EXECUTE;
  logic [31:0] RD1_EXECUTE, RD2_EXECUTE, ImmExt_EXECUTE, pc_EXECUTE, PCPlus4_EXECUTE;
  logic [4:0]  rs1_EXECUTE, rs2_EXECUTE, rd_EXECUTE;

  decode_stage dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .pc_DECODE(pc_DECODE), .instruction_DECODE(instruction_DECODE),
    .RegWrite_WRITEBACK(RegWrite_WRITEBACK), .rd_WRITEBACK(rd_WRITEBACK),
    .Result_WRITEBACK(Result_WRITEBACK),
    .stall_DECODE(stall_DECODE), .flush_EXECUTE(flush_EXECUTE),
    .rs1_DECODE(rs1_DECODE), .rs2_DECODE(rs2_DECODE),
    .RegWrite_EXECUTE(RegWrite_EXECUTE), .MemWrite_EXECUTE(MemWrite_EXECUTE),
    .Jump_EXECUTE(Jump_EXECUTE), .Branch_EXECUTE(Branch_EXECUTE),
    .ALUSrc_EXECUTE(ALUSrc_EXECUTE), .ResultSrc_EXECUTE(ResultSrc_EXECUTE),
    .ALUControl_EXECUTE(ALUControl_EXECUTE),
    .RD1_EXECUTE(RD1_EXECUTE), .RD2_EXECUTE(RD2_EXECUTE),
    .ImmExt_EXECUTE(ImmExt_EXECUTE), .pc_EXECUTE(pc_EXECUTE),
    .PCPlus4_EXECUTE(PCPlus4_EXECUTE),
    .rs1_EXECUTE(rs1_EXECUTE), .rs2_EXECUTE(rs2_EXECUTE), .rd_EXECUTE(rd_EXECUTE)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        rw, mw, jmp, br, asrc;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    logic        imm_valid;
    logic [31:0] imm, rd1, rd2, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
  } idex_t;

  logic [31:0] mreg [32];
  idex_t       m_exp;

  function automatic logic [2:0] alu_of(input logic [31:0] ins, input bit is_r);
    int f3 = int'(ins[14:12]);
    if (f3 == 0) return (is_r && ins[30]) ? 3'b001 : 3'b000;
    if (f3 == 2) return 3'b101;
    if (f3 == 6) return 3'b011;
    if (f3 == 7) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [31:0] rf_read(input int a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite_WRITEBACK && int'(rd_WRITEBACK) == a) return Result_WRITEBACK;
`endif
    return mreg[a];
  endfunction

  function automatic idex_t model_load(input logic [31:0] ins, input logic [31:0] pc);
    idex_t e;
    int sgn = ins[31] ? -1 : 0;
    logic [31:0] ii = sgn * 4096 + ins[31:20];
    logic [31:0] is = sgn * 4096 + ins[31:25] * 32 + ins[11:7];
    logic [31:0] ib = sgn * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
    logic [31:0] ij = sgn * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
    e = '0;
    case (int'(ins[6:0]))
      'h03: begin e.rw = 1; e.asrc = 1; e.rsrc = 2'b01; e.imm = ii; e.imm_valid = 1; end
      'h23: begin e.mw = 1; e.asrc = 1; e.imm = is; e.imm_valid = 1; end
      'h33: begin e.rw = 1; e.alu = alu_of(ins, 1); end
      'h63: begin e.br = 1; e.alu = 3'b001; e.imm = ib; e.imm_valid = 1; end
      'h13: begin e.rw = 1; e.asrc = 1; e.alu = alu_of(ins, 0); e.imm = ii; e.imm_valid = 1; end
      'h6F: begin e.rw = 1; e.jmp = 1; e.rsrc = 2'b10; e.imm = ij; e.imm_valid = 1; end
      default: ;
    endcase
    e.rs1 = 5'((ins >> 15) & 31);
    e.rs2 = 5'((ins >> 20) & 31);
    e.rd  = 5'((ins >> 7) & 31);
    e.rd1 = rf_read(int'(e.rs1));
    e.rd2 = rf_read(int'(e.rs2));
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    return e;
  endfunction

  always @(posedge clk_i) begin
    if (reset_i) begin
      m_exp <= '0;
      for (int i = 0; i < 32; i++) mreg[i] <= 32'h0;
    end else begin
      if (flush_EXECUTE) m_exp <= '0;
      else if (!stall_DECODE) m_exp <= model_load(instruction_DECODE, pc_DECODE);
      if (RegWrite_WRITEBACK && rd_WRITEBACK != 0) mreg[rd_WRITEBACK] <= Result_WRITEBACK;
    end
  end

  always @(negedge clk_i) begin
    if (check_en) begin
      chk("rs1_DECODE", 32'(rs1_DECODE), (instruction_DECODE >> 15) & 31);
      chk("rs2_DECODE", 32'(rs2_DECODE), (instruction_DECODE >> 20) & 31);
      chk("RegWrite", 32'(RegWrite_EXECUTE), 32'(m_exp.rw));
      chk("MemWrite", 32'(MemWrite_EXECUTE), 32'(m_exp.mw));
      chk("Jump", 32'(Jump_EXECUTE), 32'(m_exp.jmp));
      chk("Branch", 32'(Branch_EXECUTE), 32'(m_exp.br));
      chk("ALUSrc", 32'(ALUSrc_EXECUTE), 32'(m_exp.asrc));
      chk("ResultSrc", 32'(ResultSrc_EXECUTE), 32'(m_exp.rsrc));
      chk("ALUControl", 32'(ALUControl_EXECUTE), 32'(m_exp.alu));
      if (m_exp.imm_valid) chk("ImmExt", ImmExt_EXECUTE, m_exp.imm);
      chk("RD1", RD1_EXECUTE, m_exp.rd1);
      chk("RD2", RD2_EXECUTE, m_exp.rd2);
      chk("pc_EXECUTE", pc_EXECUTE, m_exp.pc);
      chk("PCPlus4", PCPlus4_EXECUTE, m_exp.pc4);
      chk("rs1_EXECUTE", 32'(rs1_EXECUTE), 32'(m_exp.rs1));
      chk("rs2_EXECUTE", 32'(rs2_EXECUTE), 32'(m_exp.rs2));
      chk("rd_EXECUTE", 32'(rd_EXECUTE), 32'(m_exp.rd));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    RegWrite_WRITEBACK = we;
    rd_WRITEBACK       = a;
    Result_WRITEBACK   = d;
  endtask

  initial begin
    reset_i = 1'b1; pc_DECODE = 32'h0; instruction_DECODE = 32'h0;
    stall_DECODE = 1'b0; flush_EXECUTE = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check_en = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    tick();
    chk("idle RegWrite", 32'(RegWrite_EXECUTE), 32'h0);
    chk("idle PCPlus4", PCPlus4_EXECUTE, 32'h4);

    // x1..x31 read 0 after reset (R-type add x0,xi,xi)
    for (int i = 1; i < 32; i++) begin
      instruction_DECODE = (i << 20) | (i << 15) | 32'h33;
      tick();
    end
    chk("post-reset RD2 x31", RD2_EXECUTE, 32'h0);

    // addi x1,x0,5 at 0x10
    pc_DECODE = 32'h10; instruction_DECODE = 32'h00500093;
    tick();
    chk("addi ImmExt", ImmExt_EXECUTE, 32'h5);
    chk("addi ALUSrc", 32'(ALUSrc_EXECUTE), 32'h1);
    chk("addi rd", 32'(rd_EXECUTE), 32'h1);
    chk("addi PCPlus4", PCPlus4_EXECUTE, 32'h14);

    // writebacks then sw x2,-4(x1)
    instruction_DECODE = 32'h0; pc_DECODE = 32'h14;
    wb(1'b1, 5'd1, 32'hDEADBEEF); tick();
    wb(1'b1, 5'd2, 32'h00000011); tick();
    wb(1'b0, 5'd0, 32'h0);
    instruction_DECODE = 32'hFE20AE23; pc_DECODE = 32'h18;
    tick();
    chk("sw MemWrite", 32'(MemWrite_EXECUTE), 32'h1);
    chk("sw RegWrite", 32'(RegWrite_EXECUTE), 32'h0);
    chk("sw ImmExt", ImmExt_EXECUTE, 32'hFFFFFFFC);
    chk("sw RD1", RD1_EXECUTE, 32'hDEADBEEF);
    chk("sw RD2", RD2_EXECUTE, 32'h00000011);
    chk("sw ALUControl", 32'(ALUControl_EXECUTE), 32'h0);

    // read x3 in the cycle it is written
    instruction_DECODE = 32'h000182B3;
    wb(1'b1, 5'd3, 32'h55);
    tick();
`ifdef REGFILE_BYPASS_EN
    chk("same-cycle x3 read", RD1_EXECUTE, 32'h55);
`else
    chk("same-cycle x3 read", RD1_EXECUTE, 32'h0);
`endif
    wb(1'b0, 5'd0, 32'h0);
    instruction_DECODE = 32'h402081B3;
    tick();
    chk("sub ALUControl", 32'(ALUControl_EXECUTE), 32'h1);
    chk("sub rd", 32'(rd_EXECUTE), 32'h3);
    instruction_DECODE = 32'h000182B3;
    tick();
    chk("later x3 read", RD1_EXECUTE, 32'h55);

    // R-type and/or/slt, beq, lw, addi with instr[30] set
    instruction_DECODE = 32'h0020E233; tick();
    chk("or ALUControl", 32'(ALUControl_EXECUTE), 32'h3);
    instruction_DECODE = 32'h0020A233; tick();
    instruction_DECODE = 32'h0020F233; tick();
    instruction_DECODE = 32'h00208463; tick();
    chk("beq ImmExt", ImmExt_EXECUTE, 32'h8);
    chk("beq Branch", 32'(Branch_EXECUTE), 32'h1);
    instruction_DECODE = 32'h0040A303; tick();
    chk("lw ResultSrc", 32'(ResultSrc_EXECUTE), 32'h1);
    instruction_DECODE = 32'hC0000393; tick();
    chk("addi neg ImmExt", ImmExt_EXECUTE, 32'hFFFFFC00);
    chk("addi neg ALUControl", 32'(ALUControl_EXECUTE), 32'h0);

    // jal x1,-8
    instruction_DECODE = 32'hFF9FF0EF; tick();
    chk("jal Jump", 32'(Jump_EXECUTE), 32'h1);
    chk("jal ResultSrc", 32'(ResultSrc_EXECUTE), 32'h2);
    chk("jal ImmExt", ImmExt_EXECUTE, 32'hFFFFFFF8);

    // unknown opcode acts as a bubble; PC wrap
    instruction_DECODE = 32'hFFFFFFFF; pc_DECODE = 32'hFFFFFFFC; tick();
    chk("unknown RegWrite", 32'(RegWrite_EXECUTE), 32'h0);
    chk("wrap PCPlus4", PCPlus4_EXECUTE, 32'h0);

    // write to x0 is ignored
    pc_DECODE = 32'h40;
    instruction_DECODE = 32'h000002B3;
    wb(1'b1, 5'd0, 32'h1234); tick();
    wb(1'b0, 5'd0, 32'h0); tick();
    chk("x0 read", RD1_EXECUTE, 32'h0);

    // stall holds, stall+flush clears, regfile keeps writing
    instruction_DECODE = 32'h00500093; pc_DECODE = 32'h44; tick();
    stall_DECODE = 1'b1; instruction_DECODE = 32'hFF9FF0EF; pc_DECODE = 32'h48;
    wb(1'b1, 5'd4, 32'hCAFE0004);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    tick();
    chk("stall ImmExt", ImmExt_EXECUTE, 32'h5);
    chk("stall pc", pc_EXECUTE, 32'h44);
    flush_EXECUTE = 1'b1; tick();
    chk("flush pc", pc_EXECUTE, 32'h0);
    chk("flush RegWrite", 32'(RegWrite_EXECUTE), 32'h0);
    stall_DECODE = 1'b0; flush_EXECUTE = 1'b0;
    instruction_DECODE = 32'h00400033; tick();
    chk("write during stall", RD2_EXECUTE, 32'hCAFE0004);

    // reset mid-operation clears regfile and blocks the pending write
    instruction_DECODE = 32'h00500093;
    wb(1'b1, 5'd9, 32'h99);
    reset_i = 1'b1; tick();
    reset_i = 1'b0; wb(1'b0, 5'd0, 32'h0);
    instruction_DECODE = 32'h00908033; tick();
    chk("reset x1", RD1_EXECUTE, 32'h0);
    chk("reset x9", RD2_EXECUTE, 32'h0);
    tick();
    @(negedge clk_i);
    #1;
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
